// File: rtl/div_iter_sr.sv
// Multi-cycle restoring integer divider (signed/unsigned per transaction) with quotient, remainder and status flags.
// Optional macro DIV_ITER_EARLY_OUT_EN: divide-by-zero / signed overflow skip the iteration phase.
module div_iter_sr #(
    parameter int XLEN = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] data1_tdata_i,
    input  logic            data1_tvalid_i,
    output logic            data1_tready_o,
    input  logic [XLEN-1:0] data2_tdata_i,
    input  logic            data2_tuser_i,
    input  logic            data2_tvalid_i,
    output logic            data2_tready_o,
    output logic [XLEN-1:0] data_tdata_o,
    output logic [XLEN-1:0] rem_tdata_o,
    output logic [1:0]      data_tuser_o,
    output logic            data_tvalid_o,
    input  logic            data_tready_i
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept, early;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN:0]   rq;
    logic [XLEN-1:0]   dvs, a_raw, b_raw;
    logic              sgn, q_neg, r_neg;

    logic [XLEN-1:0]   a_abs, b_abs;
    logic [2*XLEN:0]   sh, step;
    logic [XLEN+1:0]   trial;
    logic [XLEN-1:0]   q_fix, r_fix;
    logic              fix_dz, fix_ovf;

    assign accept         = (state == IDLE) & data1_tvalid_i & data2_tvalid_i;
    assign data1_tready_o = accept;
    assign data2_tready_o = accept;
    assign data_tvalid_o  = (state == DONE);

`ifdef DIV_ITER_EARLY_OUT_EN
    logic in_dz, in_ovf;
    assign in_dz  = (data2_tdata_i == '0);
    assign in_ovf = data2_tuser_i & (data1_tdata_i == MIN_VAL) & (data2_tdata_i == '1);
    assign early  = in_dz | in_ovf;
`else
    assign early  = 1'b0;
`endif

    // Magnitudes are only taken for negative operands in signed mode.
    assign a_abs = (data2_tuser_i & data1_tdata_i[XLEN-1]) ? -data1_tdata_i : data1_tdata_i;
    assign b_abs = (data2_tuser_i & data2_tdata_i[XLEN-1]) ? -data2_tdata_i : data2_tdata_i;

    // One restoring step: upper XLEN+1 bits hold the partial remainder, lower XLEN the quotient.
    always_comb begin
        sh    = rq << 1;
        trial = {1'b0, sh[2*XLEN:XLEN]} - {2'b00, dvs};
        step  = sh;
        if (!trial[XLEN+1])
            step = {trial[XLEN:0], sh[XLEN-1:1], 1'b1};
    end

    always_comb begin
        q_fix   = q_neg ? -rq[XLEN-1:0] : rq[XLEN-1:0];
        r_fix   = r_neg ? -rq[2*XLEN-1:XLEN] : rq[2*XLEN-1:XLEN];
        fix_dz  = (b_raw == '0);
        fix_ovf = sgn & (a_raw == MIN_VAL) & (b_raw == '1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = early ? FIX : CALC;
            CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (data_tready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt          <= '0;
            rq           <= '0;
            dvs          <= '0;
            a_raw        <= '0;
            b_raw        <= '0;
            sgn          <= 1'b0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            data_tdata_o <= '0;
            rem_tdata_o  <= '0;
            data_tuser_o <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_raw <= data1_tdata_i;
                    b_raw <= data2_tdata_i;
                    sgn   <= data2_tuser_i;
                    dvs   <= b_abs;
                    rq    <= {{(XLEN+1){1'b0}}, a_abs};
                    q_neg <= data2_tuser_i & (data1_tdata_i[XLEN-1] ^ data2_tdata_i[XLEN-1]);
                    r_neg <= data2_tuser_i & data1_tdata_i[XLEN-1];
                    cnt   <= CNT_W'(XLEN);
                end
                CALC: begin
                    rq  <= step;
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    // Divide-by-zero wins over overflow; both ignore the iteration result.
                    if (fix_dz) begin
                        data_tdata_o <= '1;
                        rem_tdata_o  <= a_raw;
                        data_tuser_o <= 2'b01;
                    end else if (fix_ovf) begin
                        data_tdata_o <= MIN_VAL;
                        rem_tdata_o  <= '0;
                        data_tuser_o <= 2'b10;
                    end else begin
                        data_tdata_o <= q_fix;
                        rem_tdata_o  <= r_fix;
                        data_tuser_o <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
